// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling.
// A 2-flop synchronizer cleans up rx. A four-state FSM then finds the middle of the
// start bit and samples each data bit and the stop bit at mid-bit. Each completed frame
// is presented as a one-clock done pulse with the received word and a framing-error flag.
module uart_rx_oversample #(
  parameter int D_bit     = 8,
  parameter int stop_tick = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             s_tick,
  output logic [D_bit-1:0] rx_out,
  output logic             rx_done_tick,
  output logic             frame_err
);

  // Tick counter must reach 15 for data bits and stop_tick-1 for the stop bit
  localparam int CW = ($clog2(stop_tick) > 4) ? $clog2(stop_tick) : 4;
  localparam int NW = ($clog2(D_bit) > 1) ? $clog2(D_bit) : 1;

  localparam logic [CW-1:0] START_MID = CW'(7);
  localparam logic [CW-1:0] BIT_END   = CW'(15);
  localparam logic [CW-1:0] STOP_END  = CW'(stop_tick - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(D_bit - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic             sync_meta_r;
  logic             sync_r;
  logic             rx_s;

  state_t           state_r,     state_s;
  logic [CW-1:0]    s_cnt_r,     s_cnt_s;
  logic [NW-1:0]    n_r,         n_s;
  logic [D_bit-1:0] shift_r,     shift_s;
  logic [D_bit-1:0] rx_out_r,    rx_out_s;
  logic             done_r,      done_s;
  logic             frame_err_r, frame_err_s;

  assign rx_s         = sync_r;
  assign rx_out       = rx_out_r;
  assign rx_done_tick = done_r;
  assign frame_err    = frame_err_r;

  // Two-flop synchronizer for the asynchronous serial line; resets to the idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
    end else begin
      sync_meta_r <= rx;
      sync_r      <= sync_meta_r;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      s_cnt_r     <= '0;
      n_r         <= '0;
      shift_r     <= '0;
      rx_out_r    <= '0;
      done_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      s_cnt_r     <= s_cnt_s;
      n_r         <= n_s;
      shift_r     <= shift_s;
      rx_out_r    <= rx_out_s;
      done_r      <= done_s;
      frame_err_r <= frame_err_s;
    end
  end

  // Next-state logic: mid-bit sampling driven by the 16x tick
  always_comb begin
    state_s     = state_r;
    s_cnt_s     = s_cnt_r;
    n_s         = n_r;
    shift_s     = shift_r;
    rx_out_s    = rx_out_r;
    done_s      = 1'b0;
    frame_err_s = frame_err_r;

    case (state_r)
      ST_IDLE: begin
        // Falling edge on the line: begin timing the start bit without waiting for a tick
        if (!rx_s) begin
          state_s = ST_START;
          s_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_cnt_r == START_MID) begin
            // Mid start bit: still low means a real frame, otherwise a glitch
            if (!rx_s) begin
              state_s = ST_DATA;
              s_cnt_s = '0;
              n_s     = '0;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_r == BIT_END) begin
            // Mid data bit: shift in LSB-first
            s_cnt_s = '0;
            shift_s = {rx_s, shift_r[D_bit-1:1]};
            if (n_r == LAST_BIT) begin
              state_s = ST_STOP;
            end else begin
              n_s = n_r + NW'(1);
            end
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_r == STOP_END) begin
            // Stop sample: publish the word even on a framing error, flagged by frame_err.
            // Returning to IDLE mid-stop-bit lets a following frame start with no gap.
            rx_out_s    = shift_r;
            frame_err_s = ~rx_s;
            done_s      = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            s_cnt_s = s_cnt_r + CW'(1);
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        state_s = ST_IDLE;
        s_cnt_s = '0;
        n_s     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Randomized scoreboard bench for uart_rx_oversample.
// A behavioural transmitter drives frames onto rx and queues the word and framing-error
// flag each frame should yield. An independent monitor pops the queue on every done pulse.
module tb_uart_rx_oversample;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       s_tick;
  logic [7:0] rx_out;
  logic       rx_done_tick;
  logic       frame_err;

  uart_rx_oversample #(.D_bit(8), .stop_tick(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_out       (rx_out),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         tick_div    = 27;
  int         div_cnt     = 0;
  int         tick_count  = 0;
  int         done_count  = 0;
  int         last_done_tick = 0;
  int         last_start_tick = 0;
  logic [8:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clock wide, every tick_div clocks
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div_cnt >= tick_div - 1) begin
        div_cnt = 0;
        s_tick  = 1'b1;
      end else begin
        div_cnt = div_cnt + 1;
        s_tick  = 1'b0;
      end
    end
  end

  // Running tick count, used to time the done pulse against the start edge
  always @(posedge clk) begin
    if (s_tick) tick_count <= tick_count + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #2;
  endtask

  // Behavioural transmitter: start bit, LSB-first data, one stop bit of 16 ticks.
  // A bad stop bit is held low only around its middle so the line recovers before
  // the next frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
    exp_q.push_back({~stop_ok, data});
    rx = 1'b0;
    last_start_tick = tick_count;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      rx = data[b];
      wait_ticks(16);
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      rx = 1'b0;
      wait_ticks(12);
      rx = 1'b1;
      wait_ticks(4);
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string nm);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 4000) begin
      @(posedge clk);
      budget = budget + 1;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest queued frame
  initial begin
    logic       prev_done;
    logic [8:0] e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rx_done_tick === 1'b1) begin
        done_count     = done_count + 1;
        last_done_tick = tick_count;
        chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors     = vectors + 1;
          miscompares = miscompares + 1;
          $display("FAIL unexpected_done: got rx_out=0x%0h, expected no pulse", rx_out);
        end else begin
          e = exp_q.pop_front();
          chk("rx_out", {24'd0, rx_out}, {24'd0, e[7:0]});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
        end
      end
      prev_done = rx_done_tick;
    end
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [7:0] b;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_out", {24'd0, rx_out}, 32'd0);
    chk("reset_done", {31'd0, rx_done_tick}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    wait_ticks(20);

    // Single frame at 27 clocks per tick, with done timing against the start edge
    d0 = done_count;
    send_frame(8'hA5, 1'b1);
    drain("a5_drain");
    chk("a5_done_count", done_count - d0, 1);
    vectors = vectors + 1;
    if ((last_done_tick - last_start_tick) < 151 || (last_done_tick - last_start_tick) > 153) begin
      miscompares = miscompares + 1;
      $display("FAIL a5_latency: got %0d ticks, expected 151..153", last_done_tick - last_start_tick);
    end

    tick_div = 8;
    wait_ticks(4);

    // Short glitch rejected in START
    d0 = done_count;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(30);
    chk("glitch_no_done", done_count - d0, 0);
    chk("glitch_rx_out", {24'd0, rx_out}, 32'hA5);
    chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);

    // Framing error, then a clean frame clears the flag
    send_frame(8'h3C, 1'b0);
    wait_ticks(24);
    send_frame(8'h01, 1'b1);
    drain("ferr_drain");
    chk("ferr_cleared", {31'd0, frame_err}, 32'd0);
    wait_ticks(8);

    // Back-to-back frames with no idle gap
    d0 = done_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drain("b2b_drain");
    chk("b2b_done_count", done_count - d0, 3);
    wait_ticks(8);

    // Reset during data bit 3 of 0x96 aborts the frame
    d0 = done_count;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = ((8'h96 >> i) & 8'h01) != 8'h00;
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_rx_out", {24'd0, rx_out}, 32'd0);
    chk("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rx  = 1'b1;
    rst = 1'b1;
    wait_ticks(24);
    chk("midrst_no_done", done_count - d0, 0);
    send_frame(8'h69, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_done_count", done_count - d0, 1);
    wait_ticks(8);

    // Loopback of random bytes, back to back
    d0 = done_count;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
    end
    drain("loop_drain");
    chk("loop_done_count", done_count - d0, 8);

    wait_ticks(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
